// File: rtl/memory_access_unit_pkg.sv
// Shared encodings for the memory stage: writeback source select, SPI MMIO
// register offsets, abort read data and handshake FSM states.
package mem_pkg;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  localparam logic [7:0] SPI_TXDATA = 8'h00;
  localparam logic [7:0] SPI_RXDATA = 8'h04;
  localparam logic [7:0] SPI_STATUS = 8'h08;

  localparam logic [31:0] SPI_ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mmio_state_t;

endpackage

// File: rtl/mmio_handshake_fsm.sv
// Tracks an outstanding SPI MMIO access: waits for ack, times out after
// TIMEOUT_CYCLES stalled cycles, and raises the sticky error flag on abort.
//
//   state | meaning
//   IDLE  | no access outstanding; an MMIO access may complete here on a same-cycle ack
//   BUSY  | access issued, waiting for ack; cnt counts cycles spent here
module mmio_handshake_fsm
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic isMmio,
  input  logic spiAck,
  output logic StallM,
  output logic abort,
  output logic spiErr
);

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  mmio_state_t state, stateNext;
  logic [7:0]  cnt, cntNext;
  logic        errNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      spiErr <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      spiErr <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    errNext   = spiErr;
    case (state)
      ST_IDLE: begin
        if (isMmio && !spiAck) begin
          stateNext = ST_BUSY;
          cntNext   = '0;
        end
      end
      ST_BUSY: begin
        cntNext = cnt + 8'd1;
        if (spiAck || abort) stateNext = ST_IDLE;
        if (abort) errNext = 1'b1;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // An ack on the limit cycle wins over the abort.
  always_comb begin
    abort  = !rst && (state == ST_BUSY) && isMmio && !spiAck && (cnt == CNT_LIMIT);
    StallM = !rst && isMmio && !spiAck && !abort;
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage: DMEM loads/stores, SPI MMIO window routing with stall, and
// the MEM/WB pipeline register.
module memory_access_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] SPI_BASE       = 32'h4000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata,
  output logic        spi_req,
  output logic        spi_we,
  output logic [7:0]  spi_addr,
  output logic [31:0] spi_wdata,
  input  logic        spi_ack,
  input  logic [31:0] spi_rdata,
  output logic        StallM,
  output logic        spi_err,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
);

  logic isMem, isMmio, isDmem, ackValid, abort;

  assign isMem  = MemWriteM | (ResultSrcM == RESULT_LOAD);
  assign isMmio = isMem & (ALU_ResultM[31:8] == SPI_BASE[31:8]);
  assign isDmem = isMem & ~isMmio;

  assign dmem_addr  = ALU_ResultM;
  assign dmem_wdata = WriteDataM;
  assign dmem_we    = MemWriteM & isDmem & ~rst;

  // Request fields are zeroed outside an access so the controller sees a clean bus.
  assign spi_req   = isMmio & ~rst;
  assign spi_we    = spi_req & MemWriteM;
  assign spi_addr  = spi_req ? ALU_ResultM[7:0] : 8'h00;
  assign spi_wdata = spi_req ? WriteDataM : 32'h0;
  assign ackValid  = spi_ack & spi_req;

  mmio_handshake_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .isMmio (isMmio),
    .spiAck (ackValid),
    .StallM (StallM),
    .abort  (abort),
    .spiErr (spi_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= RESULT_ALU;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      if (ackValid)   ReadDataW <= spi_rdata;
      else if (abort) ReadDataW <= SPI_ERR_DATA;
      else            ReadDataW <= dmem_rdata;
    end
  end

endmodule
